// File: rtl/handshake_constant_table.sv
// Handshake constant source backed by a compile-time table: each accepted control
// token emits one table entry into a 2-slot output buffer (fixed entry 0 or cycling).
module handshake_constant_table #(
  parameter int                            DATA_WIDTH = 32,
  parameter int                            DEPTH      = 4,
  parameter logic [DEPTH*DATA_WIDTH-1:0]   CONSTS     = '0,
  parameter int                            MODE       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] table_w [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_table
      assign table_w[gi] = CONSTS[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  logic [IDX_W-1:0]      idx_reg;
  logic [IDX_W-1:0]      idx_next;
  logic [DATA_WIDTH-1:0] slot_reg [2];
  logic                  head_reg;
  logic [1:0]            occ_reg;
  logic                  rst_released_reg;

  logic push;
  logic pop;
  logic tail;

  // Ready depends only on registers, so no combinational path from outs_ready.
  assign ctrl_ready = (occ_reg != 2'd2) & rst_released_reg;
  assign outs_valid = (occ_reg != 2'd0);
  assign outs       = outs_valid ? slot_reg[head_reg] : '0;

  assign push = ctrl_valid & ctrl_ready;
  assign pop  = outs_valid & outs_ready;
  assign tail = head_reg ^ occ_reg[0];

  always_comb begin
    idx_next = idx_reg;
    if ((MODE == 1) && (DEPTH > 1)) begin
      if (idx_reg == IDX_W'(DEPTH - 1)) idx_next = '0;
      else                              idx_next = idx_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_reg          <= '0;
      slot_reg[0]      <= '0;
      slot_reg[1]      <= '0;
      head_reg         <= 1'b0;
      occ_reg          <= 2'd0;
      rst_released_reg <= 1'b0;
    end else begin
      rst_released_reg <= 1'b1;
      // The table pointer moves only on accepted tokens; stalls leave it alone.
      if (push) begin
        slot_reg[tail] <= table_w[idx_reg];
        idx_reg        <= idx_next;
      end
      if (pop) head_reg <= ~head_reg;
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + 2'd1;
        2'b01:   occ_reg <= occ_reg - 2'd1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_constant_table.sv
// Scoreboard bench: three instances (cycling DEPTH=3, fixed MODE=0, DEPTH=1) checked
// against an arithmetic model of which table entry each accepted token should yield.
module tb_handshake_constant_table;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cv   [3];
  logic       ordy [3];
  logic       cr   [3];
  logic       ov   [3];
  logic [7:0] ou   [3];

  always #5 clk = ~clk;

  handshake_constant_table #(.DATA_WIDTH(8), .DEPTH(3), .CONSTS(24'h33_22_11), .MODE(1)) u_cyc (
    .clk(clk), .rst(rst), .ctrl_valid(cv[0]), .ctrl_ready(cr[0]),
    .outs(ou[0]), .outs_valid(ov[0]), .outs_ready(ordy[0]));

  handshake_constant_table #(.DATA_WIDTH(8), .DEPTH(3), .CONSTS(24'h33_22_11), .MODE(0)) u_fix (
    .clk(clk), .rst(rst), .ctrl_valid(cv[1]), .ctrl_ready(cr[1]),
    .outs(ou[1]), .outs_valid(ov[1]), .outs_ready(ordy[1]));

  handshake_constant_table #(.DATA_WIDTH(8), .DEPTH(1), .CONSTS(8'hA5), .MODE(1)) u_one (
    .clk(clk), .rst(rst), .ctrl_valid(cv[2]), .ctrl_ready(cr[2]),
    .outs(ou[2]), .outs_valid(ov[2]), .outs_ready(ordy[2]));

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int in_n  [3] = '{0, 0, 0};
  int out_n [3] = '{0, 0, 0};
  int acc_n [3] = '{0, 0, 0};
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];
  logic       hold_pend [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] hold_val  [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // n-th token since reset: cycling instance walks 0x11,0x22,0x33; others are fixed.
  function automatic logic [7:0] model(input int k, input int n);
    case (k)
      0:       return 8'(8'h11 * ((n % 3) + 1));
      1:       return 8'h11;
      default: return 8'hA5;
    endcase
  endfunction

  function automatic int q_size(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // Stimulus side of the scoreboard: record the expected constant of every accept.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) begin
      q0.delete(); q1.delete(); q2.delete();
      for (int k = 0; k < 3; k++) acc_n[k] = 0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (cv[k] && cr[k]) begin
          e = model(k, acc_n[k]);
          case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
          endcase
          acc_n[k]++;
          in_n[k]++;
        end
      end
    end
  end

  // Monitor: compare every transfer against the queue head, and check hold behaviour.
  always @(negedge clk) begin
    logic [7:0] e;
    for (int k = 0; k < 3; k++) begin
      if (!rst) begin
        hold_pend[k] = 1'b0;
      end else begin
        if (hold_pend[k]) begin
          check("hold_valid", 32'(ov[k]), 32'd1);
          check("hold_data", 32'(ou[k]), 32'(hold_val[k]));
        end
        if (ov[k] && ordy[k]) begin
          if (q_size(k) == 0) begin
            check("unexpected_output", 32'(ou[k]), 32'hFFFF_FFFF);
          end else begin
            case (k)
              0:       e = q0.pop_front();
              1:       e = q1.pop_front();
              default: e = q2.pop_front();
            endcase
            check("out_data", 32'(ou[k]), 32'(e));
          end
          $display("inst %0d out %02h", k, ou[k]);
          out_n[k]++;
        end
        hold_pend[k] = ov[k] && !ordy[k];
        hold_val[k]  = ou[k];
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int acc;
    for (int k = 0; k < 3; k++) begin cv[k] = 1'b0; ordy[k] = 1'b0; end

    // Reset held: outputs quiet regardless of inputs.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        cv[k]   = 1'($urandom_range(0, 1));
        ordy[k] = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        check("rst_valid", 32'(ov[k]), 32'd0);
        check("rst_outs",  32'(ou[k]), 32'd0);
        check("rst_ready", 32'(cr[k]), 32'd0);
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin cv[k] = 1'b0; ordy[k] = 1'b0; end
    rst = 1'b1;
    @(negedge clk);
    check("ready_before_edge", 32'(cr[0]), 32'd0);
    @(posedge clk); #1;
    check("ready_after_edge", 32'(cr[0]), 32'd1);

    // Streaming with wrap, no bubbles.
    cv[0] = 1'b1; ordy[0] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("stream_ready", 32'(cr[0]), 32'd1);
      if (i > 0) check("stream_valid", 32'(ov[0]), 32'd1);
      @(posedge clk); #1;
    end
    cv[0] = 1'b0;
    @(negedge clk);
    check("stream_last_valid", 32'(ov[0]), 32'd1);
    check("stream_last_data",  32'(ou[0]), 32'h11);
    @(posedge clk); #1;
    @(negedge clk);
    check("stream_drained", 32'(ov[0]), 32'd0);

    // Backpressure: two absorbed, then full.
    do_reset();
    cv[0] = 1'b1; ordy[0] = 1'b0; acc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cr[0]) acc++;
      @(posedge clk); #1;
    end
    check("bp_accepts", 32'(acc), 32'd2);
    @(negedge clk);
    check("bp_ready_low", 32'(cr[0]), 32'd0);
    check("bp_valid", 32'(ov[0]), 32'd1);
    check("bp_head", 32'(ou[0]), 32'h11);
    @(posedge clk); #1;
    cv[0] = 1'b0; ordy[0] = 1'b1;
    @(negedge clk);
    check("full_pop_ready", 32'(cr[0]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("ready_after_pop", 32'(cr[0]), 32'd1);
    check("bp_second", 32'(ou[0]), 32'h22);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_empty", 32'(ov[0]), 32'd0);
    @(posedge clk); #1;
    cv[0] = 1'b1;
    @(posedge clk); #1;
    cv[0] = 1'b0;
    @(negedge clk);
    check("bp_third", 32'(ou[0]), 32'h33);
    @(posedge clk); #1;

    // MODE 0: five tokens under random backpressure.
    for (int i = 0; i < 100 && in_n[1] < 5; i++) begin
      cv[1]   = 1'($urandom_range(0, 1));
      ordy[1] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    cv[1] = 1'b0; ordy[1] = 1'b1;
    check("m0_in_count", 32'(in_n[1]), 32'd5);
    for (int i = 0; i < 10 && out_n[1] < 5; i++) begin @(posedge clk); #1; end
    check("m0_out_count", 32'(out_n[1]), 32'd5);
    check("m0_queue_empty", 32'(q1.size()), 32'd0);

    // Asynchronous reset with two buffered tokens.
    do_reset();
    cv[0] = 1'b1; ordy[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cv[0] = 1'b0;
    check("pre_async_valid", 32'(ov[0]), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_valid", 32'(ov[0]), 32'd0);
    check("async_outs",  32'(ou[0]), 32'd0);
    check("async_ready", 32'(cr[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    cv[0] = 1'b1; ordy[0] = 1'b1;
    @(posedge clk); #1;
    cv[0] = 1'b0;
    @(negedge clk);
    check("after_async_data", 32'(ou[0]), 32'h11);
    @(posedge clk); #1;

    // DEPTH 1: random traffic.
    for (int i = 0; i < 200; i++) begin
      cv[2]   = 1'($urandom_range(0, 1));
      ordy[2] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    cv[2] = 1'b0; ordy[2] = 1'b1;
    for (int i = 0; i < 10 && out_n[2] != in_n[2]; i++) begin @(posedge clk); #1; end
    check("d1_balance", 32'(out_n[2]), 32'(in_n[2]));
    check("d1_queue_empty", 32'(q2.size()), 32'd0);

    check("final_q0_empty", 32'(q0.size()), 32'd0);
    check("final_q1_empty", 32'(q1.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/handshake_constant_table.md
# handshake_constant_table

Parametrised successor to the single-value handshake constant source. On each accepted control token it emits one entry from a compile-time table of DEPTH constants, either always entry 0 or cycling through the table. Output is decoupled by a 2-entry registered buffer, so `ctrl_ready` does not depend combinationally on `outs_ready`. It sits in dataflow graphs wherever a constant or periodic constant pattern feeds a compute node.

## Interface
- DATA_WIDTH, 32: width of each constant and of `outs`.
- DEPTH, 4: number of table entries; legal range ≥ 1.
- CONSTS, all zeros: DEPTH*DATA_WIDTH-bit packed table; entry i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- MODE, 1: 0 = fixed, always entry 0; 1 = cycle 0,1,…,DEPTH-1,0,…
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- ctrl_valid  in  1  control token present.
- ctrl_ready  out  1  block can accept a token.
- outs  out  DATA_WIDTH  head-of-buffer constant.
- outs_valid  out  1  `outs` holds a valid constant.
- outs_ready  in  1  downstream accepts `outs`.

## Operation
- State:
  - `idx`: table pointer, width max(1, clog2(DEPTH)).
  - Two data slots organised as a FIFO with head pointer.
  - `occ`: occupancy, 0..2.
- Accept: `push = ctrl_valid & ctrl_ready`.
  - On push, write CONSTS[idx] into the tail slot.
  - In MODE 1, also advance `idx`: `idx == DEPTH-1` wraps to 0, otherwise `idx + 1`.
  - In MODE 0, `idx` stays 0.
- Emit: `pop = outs_valid & outs_ready`; on pop, the head advances.
- Occupancy update:
  - push & !pop: `occ + 1`
  - pop & !push: `occ - 1`
  - both: unchanged
- `ctrl_ready = (occ != 2) & rst_released`. It is a function of registers only, so there is no ready-to-ready combinational path.
- `outs_valid = (occ != 0)`.
- `outs` = head slot when `occ != 0`, else all zeros.
- Ordering: constants leave in acceptance order; no token is dropped or duplicated.
- DEPTH = 1: `idx` is constant 0 and MODE has no effect.
- `idx` is never reset by a stall. It advances only on push, never on pop.

## Timing
- Reset (`rst` low, asynchronous): `occ`=0, `idx`=0, slots=0.
  - Outputs during reset: `outs_valid`=0, `outs`=0, `ctrl_ready`=0.
  - On the first rising clk edge after `rst` goes high, `ctrl_ready` becomes 1.
- Latency: a token accepted at edge N gives `outs_valid`=1 with its constant during cycle N+1, i.e. 1 cycle.
- Throughput: 1 token/cycle sustained while `outs_ready`=1.
  - Occupancy holds at 1 under simultaneous push/pop.
- Backpressure:
  - With `outs_ready`=0, two tokens are absorbed, then `ctrl_ready`=0.
  - After the first pop, `ctrl_ready` returns to 1 in the next cycle.
- Full + pop in the same cycle: no push that cycle, because `ctrl_ready` was 0. `occ` goes 2→1.
- Empty: a pop cannot occur because `outs_valid`=0. `outs_ready` is ignored.
- Reset asserted mid-operation: buffered constants are discarded and `idx` returns to 0 immediately, without waiting for a clock edge.
- Output stability: `outs` and `outs_valid` are stable while `outs_valid`=1 and `outs_ready`=0 (AXI-style hold).

## Test plan
Common configuration: DATA_WIDTH=8, DEPTH=3, CONSTS=24'h33_22_11 (entry0=0x11), MODE=1, unless stated otherwise.

- Reset check: hold `rst`=0, toggle clk and inputs -> `outs_valid`=0, `outs`=0x00, `ctrl_ready`=0. Release -> `ctrl_ready`=1 after one edge.
- Streaming with wrap: `ctrl_valid`=1 and `outs_ready`=1 for 7 cycles -> `outs` sequence 0x11,0x22,0x33,0x11,0x22,0x33,0x11, each one cycle after acceptance, with no bubbles.
- Backpressure: `outs_ready`=0 and `ctrl_valid`=1 -> exactly 2 accepts, then `ctrl_ready`=0 with `outs`=0x11 held. Raise `outs_ready` -> 0x11 then 0x22 drain in order; the next accepted token yields 0x33.
- MODE=0: 5 tokens under random `outs_ready` -> all outputs are 0x11 and the count equals 5.
- Async reset mid-stream: assert `rst` low between edges with `occ`=2 and `idx`=2 -> `outs_valid` drops immediately. After release, the first token yields 0x11.
- DEPTH=1, CONSTS=8'hA5, MODE=1, random valid/ready for 200 cycles -> every output is 0xA5 and tokens in equal tokens out.
